// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS32 front end.
// Holds the fetch FIFO entry layout, the default reset PC and instruction field positions.
package mips_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNC_MSB   = 5;
    localparam int FUNC_LSB   = 0;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instr, pc} entries between instruction memory and decode.
// Ports: clk, rst, push_i/din_i, pop_i, flush_i (dominates push), head_o, count_o.
module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  fetch_entry_t din_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic do_pop;
    logic do_push;

    assign do_pop  = pop_i && (count_q != '0);
    // A push into a full FIFO is only accepted when a pop frees a slot the same cycle.
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: sequential PC generation, in-order memory requests, prefetch buffering, redirects.
// Ports: imem_req_* toward memory, imem_resp_* from memory, redirect_* from branch logic, if_* to decode.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_head;
    fetch_entry_t    fifo_din;

    logic [CW:0]     occupancy;
    logic            req_fire;
    logic            resp_ok;
    logic            push;
    logic            pop;
    logic [CW-1:0]   inflight_dec;

    // Buffered plus outstanding words never exceed DEPTH, so responses always fit.
    assign occupancy = (CW+1)'(fifo_count) + (CW+1)'(inflight_q);

    assign imem_req_valid = !rst && !redirect_valid
                          && (occupancy < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_ok      = imem_resp_valid && (inflight_q != '0);
    assign inflight_dec = inflight_q - CW'(resp_ok);
    assign push         = resp_ok && (drop_q == '0);
    assign pop          = if_valid && if_ready;

    assign fifo_din = '{instr: imem_resp_data, pc: resp_pc_q};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_dec;
        drop_d     = drop_q;
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_pc);
            resp_pc_d  = word_align(redirect_pc);
            // Everything still outstanding belongs to the old path.
            drop_d     = inflight_dec;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                inflight_d = inflight_dec + CW'(1);
            end
            if (resp_ok && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (fifo_din),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

    assign if_valid    = (fifo_count != '0);
    assign if_instr    = if_valid ? fifo_head.instr : '0;
    assign if_pc       = if_valid ? fifo_head.pc : '0;
    assign if_pc_plus4 = if_valid ? (fifo_head.pc + 32'd4) : '0;

    resp_order_a: assert property (
        @(posedge clk) disable iff (rst)
        imem_resp_valid |-> (inflight_q != '0)
    );

endmodule
